// File: rtl/rob_multi.sv
// Reorder buffer: N-port writeback, dual in-order commit, one-cycle lookup, flush on mispredicted branch.
// Latency: commit/lookup outputs registered one cycle after the deciding edge; issue_ready/issue_id combinational.
module rob_multi #(
    parameter int ROB_W = 4,
    parameter int XLEN  = 32,
    parameter int NWB   = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  rdy_in,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    output logic [ROB_W-1:0]      issue_id,
    input  logic [1:0]            issue_type,
    input  logic [4:0]            issue_rd,
    input  logic [XLEN-1:0]       issue_pc,
    input  logic [XLEN-1:0]       issue_aux,
    input  logic [NWB-1:0]        wb_valid,
    input  logic [NWB*ROB_W-1:0]  wb_id,
    input  logic [NWB*XLEN-1:0]   wb_val,
    output logic [1:0]            commit_valid,
    output logic [2*ROB_W-1:0]    commit_id,
    output logic [9:0]            commit_rd,
    output logic [2*XLEN-1:0]     commit_val,
    output logic [1:0]            commit_we,
    output logic                  st_commit,
    output logic [ROB_W-1:0]      st_commit_id,
    output logic                  flush,
    output logic                  redirect_valid,
    output logic [XLEN-1:0]       redirect_pc,
    input  logic [ROB_W-1:0]      lk_id_a,
    input  logic [ROB_W-1:0]      lk_id_b,
    input  logic                  lk_dep_a,
    input  logic                  lk_dep_b,
    input  logic [XLEN-1:0]       lk_rf_a,
    input  logic [XLEN-1:0]       lk_rf_b,
    output logic                  lk_pend_a,
    output logic                  lk_pend_b,
    output logic [ROB_W-1:0]      lk_tag_a,
    output logic [ROB_W-1:0]      lk_tag_b,
    output logic [XLEN-1:0]       lk_data_a,
    output logic [XLEN-1:0]       lk_data_b,
    output logic [ROB_W-1:0]      head_id,
    output logic [ROB_W:0]        count
);
    localparam int             DEPTH     = 1 << ROB_W;
    localparam logic [ROB_W:0] DEPTH_CNT = (ROB_W+1)'(DEPTH);
    localparam logic [1:0]     T_BR      = 2'b00;
    localparam logic [1:0]     T_ST      = 2'b01;
    localparam logic [1:0]     T_JALR    = 2'b10;
    localparam logic [1:0]     T_RG      = 2'b11;

    logic [DEPTH-1:0]  busy_q, done_q;
    logic [1:0]        type_q [DEPTH];
    logic [4:0]        rd_q   [DEPTH];
    logic [XLEN-1:0]   aux_q  [DEPTH];
    logic [XLEN-1:0]   val_q  [DEPTH];
    logic [ROB_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [ROB_W:0]    count_q, count_d;

    logic [1:0]        commit_valid_q, commit_valid_d;
    logic [2*ROB_W-1:0] commit_id_q, commit_id_d;
    logic [9:0]        commit_rd_q, commit_rd_d;
    logic [2*XLEN-1:0] commit_val_q, commit_val_d;
    logic [1:0]        commit_we_q, commit_we_d;
    logic              st_commit_q, st_commit_d;
    logic [ROB_W-1:0]  st_commit_id_q, st_commit_id_d;
    logic              flush_q, flush_d;
    logic              redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
    logic              lk_pend_a_q, lk_pend_a_d, lk_pend_b_q, lk_pend_b_d;
    logic [ROB_W-1:0]  lk_tag_a_q, lk_tag_a_d, lk_tag_b_q, lk_tag_b_d;
    logic [XLEN-1:0]   lk_data_a_q, lk_data_a_d, lk_data_b_q, lk_data_b_d;

    logic              active, issue_fire, c0, c1;
    logic [NWB-1:0]    wb_hit;
    logic [ROB_W-1:0]  h0, h1;
    logic [1:0]        t0, t1, n_commit;

    // The retire logic never needs the instruction address.
    logic unused_pc;
    assign unused_pc = ^issue_pc;

    // Nothing is accepted during the flush cycle or while stalled.
    assign active      = rdy_in && !flush_q;
    assign issue_ready = count_q < DEPTH_CNT;
    assign issue_id    = tail_q;
    assign issue_fire  = issue_valid && issue_ready && active;

    always_comb begin
        wb_hit = '0;
        for (int k = 0; k < NWB; k++)
            wb_hit[k] = active && wb_valid[k] && busy_q[wb_id[k*ROB_W +: ROB_W]];
    end

    always_comb begin
        h0 = head_q;
        h1 = head_q + ROB_W'(1);
        t0 = type_q[h0];
        t1 = type_q[h1];
        c0 = active && busy_q[h0] && done_q[h0];
        c1 = c0 && (t0 == T_RG || t0 == T_ST) && busy_q[h1] && done_q[h1]
                && (t1 == T_RG || t1 == T_ST) && !(t0 == T_ST && t1 == T_ST);
        n_commit = {1'b0, c0} + {1'b0, c1};
        head_d   = head_q + ROB_W'(n_commit);
        tail_d   = tail_q + ROB_W'(issue_fire);
        count_d  = count_q + (ROB_W+1)'(issue_fire) - (ROB_W+1)'(n_commit);

        commit_valid_d   = {c1, c0};
        commit_id_d      = '0;
        commit_rd_d      = '0;
        commit_val_d     = '0;
        commit_we_d      = '0;
        st_commit_d      = 1'b0;
        st_commit_id_d   = '0;
        flush_d          = 1'b0;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = '0;
        if (c0) begin
            commit_id_d[0 +: ROB_W] = h0;
            commit_rd_d[0 +: 5]     = rd_q[h0];
            commit_val_d[0 +: XLEN] = (t0 == T_JALR) ? aux_q[h0] : val_q[h0];
            commit_we_d[0]          = (t0 == T_RG || t0 == T_JALR) && (rd_q[h0] != 5'd0);
            if (t0 == T_ST) begin
                st_commit_d    = 1'b1;
                st_commit_id_d = h0;
            end
            if (t0 == T_JALR || (t0 == T_BR && val_q[h0] != aux_q[h0])) begin
                redirect_valid_d = 1'b1;
                redirect_pc_d    = val_q[h0];
                flush_d          = (t0 == T_BR);
            end
        end
        if (c1) begin
            commit_id_d[ROB_W +: ROB_W] = h1;
            commit_rd_d[5 +: 5]         = rd_q[h1];
            commit_val_d[XLEN +: XLEN]  = val_q[h1];
            commit_we_d[1]              = (t1 == T_RG) && (rd_q[h1] != 5'd0);
            if (t1 == T_ST) begin
                st_commit_d    = 1'b1;
                st_commit_id_d = h1;
            end
        end
    end

    // Same-cycle writeback beats stored value; lowest port wins on a tie.
    function automatic logic [XLEN+ROB_W:0] lookup(input logic dep,
                                                  input logic [ROB_W-1:0] id,
                                                  input logic [XLEN-1:0] rf);
        logic            hit;
        logic [XLEN-1:0] fwd;
        hit = 1'b0;
        fwd = '0;
        for (int k = NWB-1; k >= 0; k--) begin
            if (wb_valid[k] && wb_id[k*ROB_W +: ROB_W] == id) begin
                hit = 1'b1;
                fwd = wb_val[k*XLEN +: XLEN];
            end
        end
        if (!dep)
            return {1'b0, {ROB_W{1'b0}}, rf};
        if (hit)
            return {1'b0, {ROB_W{1'b0}}, fwd};
        if (done_q[id])
            return {1'b0, {ROB_W{1'b0}}, val_q[id]};
        return {1'b1, id, {XLEN{1'b0}}};
    endfunction

    assign {lk_pend_a_d, lk_tag_a_d, lk_data_a_d} = lookup(lk_dep_a, lk_id_a, lk_rf_a);
    assign {lk_pend_b_d, lk_tag_b_d, lk_data_b_d} = lookup(lk_dep_b, lk_id_b, lk_rf_b);

    always_ff @(posedge clk_in) begin
        if (!rst_n_in || flush_q) begin
            busy_q  <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (rdy_in) begin
            for (int k = 0; k < NWB; k++)
                if (wb_hit[k]) done_q[wb_id[k*ROB_W +: ROB_W]] <= 1'b1;
            if (c0) begin
                busy_q[h0] <= 1'b0;
                done_q[h0] <= 1'b0;
            end
            if (c1) begin
                busy_q[h1] <= 1'b0;
                done_q[h1] <= 1'b0;
            end
            if (issue_fire) begin
                busy_q[tail_q] <= 1'b1;
                done_q[tail_q] <= 1'b0;
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_in) begin
        for (int k = 0; k < NWB; k++)
            if (wb_hit[k]) val_q[wb_id[k*ROB_W +: ROB_W]] <= wb_val[k*XLEN +: XLEN];
        if (issue_fire) begin
            type_q[tail_q] <= issue_type;
            rd_q[tail_q]   <= issue_rd;
            aux_q[tail_q]  <= issue_aux;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            commit_valid_q   <= '0;
            commit_id_q      <= '0;
            commit_rd_q      <= '0;
            commit_val_q     <= '0;
            commit_we_q      <= '0;
            st_commit_q      <= 1'b0;
            st_commit_id_q   <= '0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            lk_pend_a_q      <= 1'b0;
            lk_pend_b_q      <= 1'b0;
            lk_tag_a_q       <= '0;
            lk_tag_b_q       <= '0;
            lk_data_a_q      <= '0;
            lk_data_b_q      <= '0;
        end else begin
            commit_valid_q   <= commit_valid_d;
            commit_id_q      <= commit_id_d;
            commit_rd_q      <= commit_rd_d;
            commit_val_q     <= commit_val_d;
            commit_we_q      <= commit_we_d;
            st_commit_q      <= st_commit_d;
            st_commit_id_q   <= st_commit_id_d;
            flush_q          <= flush_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            if (rdy_in) begin
                lk_pend_a_q <= lk_pend_a_d;
                lk_pend_b_q <= lk_pend_b_d;
                lk_tag_a_q  <= lk_tag_a_d;
                lk_tag_b_q  <= lk_tag_b_d;
                lk_data_a_q <= lk_data_a_d;
                lk_data_b_q <= lk_data_b_d;
            end
        end
    end

    assign commit_valid   = commit_valid_q;
    assign commit_id      = commit_id_q;
    assign commit_rd      = commit_rd_q;
    assign commit_val     = commit_val_q;
    assign commit_we      = commit_we_q;
    assign st_commit      = st_commit_q;
    assign st_commit_id   = st_commit_id_q;
    assign flush          = flush_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign lk_pend_a      = lk_pend_a_q;
    assign lk_pend_b      = lk_pend_b_q;
    assign lk_tag_a       = lk_tag_a_q;
    assign lk_tag_b       = lk_tag_b_q;
    assign lk_data_a      = lk_data_a_q;
    assign lk_data_b      = lk_data_b_q;
    assign head_id        = head_q;
    assign count          = count_q;
endmodule

// File: tb/tb_rob_multi.sv
// Directed bench for rob_multi: dual commit, full/wrap, flush, JALR, stores, lookup forwarding, stall.
module tb_rob_multi;
    localparam logic [1:0] BR = 2'b00, ST = 2'b01, JALR = 2'b10, RG = 2'b11;

    logic        clk_in = 1'b0;
    logic        rst_n_in, rdy_in, issue_valid, issue_ready;
    logic [3:0]  issue_id;
    logic [1:0]  issue_type;
    logic [4:0]  issue_rd;
    logic [31:0] issue_pc, issue_aux;
    logic [1:0]  wb_valid;
    logic [7:0]  wb_id;
    logic [63:0] wb_val;
    logic [1:0]  commit_valid, commit_we;
    logic [7:0]  commit_id;
    logic [9:0]  commit_rd;
    logic [63:0] commit_val;
    logic        st_commit, flush, redirect_valid;
    logic [3:0]  st_commit_id;
    logic [31:0] redirect_pc;
    logic [3:0]  lk_id_a, lk_id_b, lk_tag_a, lk_tag_b, head_id;
    logic        lk_dep_a, lk_dep_b, lk_pend_a, lk_pend_b;
    logic [31:0] lk_rf_a, lk_rf_b, lk_data_a, lk_data_b;
    logic [4:0]  count;

    int checks = 0;
    int errors = 0;

    rob_multi #(.ROB_W(4), .XLEN(32), .NWB(2)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_id(issue_id),
        .issue_type(issue_type), .issue_rd(issue_rd), .issue_pc(issue_pc), .issue_aux(issue_aux),
        .wb_valid(wb_valid), .wb_id(wb_id), .wb_val(wb_val),
        .commit_valid(commit_valid), .commit_id(commit_id), .commit_rd(commit_rd),
        .commit_val(commit_val), .commit_we(commit_we),
        .st_commit(st_commit), .st_commit_id(st_commit_id),
        .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .lk_id_a(lk_id_a), .lk_id_b(lk_id_b), .lk_dep_a(lk_dep_a), .lk_dep_b(lk_dep_b),
        .lk_rf_a(lk_rf_a), .lk_rf_b(lk_rf_b), .lk_pend_a(lk_pend_a), .lk_pend_b(lk_pend_b),
        .lk_tag_a(lk_tag_a), .lk_tag_b(lk_tag_b), .lk_data_a(lk_data_a), .lk_data_b(lk_data_b),
        .head_id(head_id), .count(count)
    );

    always #5 clk_in = ~clk_in;

    // Inputs change on the falling edge; outputs are read there too.
    task automatic step();
        @(negedge clk_in);
    endtask

    task automatic idle();
        rdy_in = 1'b1; issue_valid = 1'b0; issue_type = RG; issue_rd = '0;
        issue_pc = '0; issue_aux = '0; wb_valid = '0; wb_id = '0; wb_val = '0;
        lk_id_a = '0; lk_id_b = '0; lk_dep_a = 1'b0; lk_dep_b = 1'b0;
        lk_rf_a = '0; lk_rf_b = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_n_in = 1'b0;
        step();
        step();
        rst_n_in = 1'b1;
    endtask

    task automatic issue_one(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] aux);
        issue_valid = 1'b1; issue_type = t; issue_rd = rd; issue_aux = aux;
        issue_pc = 32'h1000;
        step();
        issue_valid = 1'b0;
    endtask

    task automatic wb2(input logic [1:0] v, input logic [3:0] id0, input logic [31:0] val0,
                       input logic [3:0] id1, input logic [31:0] val1);
        wb_valid = v; wb_id = {id1, id0}; wb_val = {val1, val0};
        step();
        wb_valid = '0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", issue_ready); end
        checks++; if (issue_id !== 4'd0) begin errors++; $display("FAIL reset_issue_id: got %0d exp 0", issue_id); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", count); end
        checks++; if (head_id !== 4'd0) begin errors++; $display("FAIL reset_head: got %0d exp 0", head_id); end
        checks++; if ({commit_valid, st_commit, flush, redirect_valid} !== 5'b0) begin
            errors++; $display("FAIL reset_pulses: got %b exp 00000", {commit_valid, st_commit, flush, redirect_valid}); end
    endtask

    task automatic test_dual_commit();
        do_reset();
        issue_one(RG, 5'd1, 32'h0);
        issue_one(RG, 5'd2, 32'h0);
        issue_one(RG, 5'd3, 32'h0);
        checks++; if (count !== 5'd3) begin errors++; $display("FAIL dual_count3: got %0d exp 3", count); end
        checks++; if (issue_id !== 4'd3) begin errors++; $display("FAIL dual_tail: got %0d exp 3", issue_id); end
        wb2(2'b11, 4'd0, 32'h11, 4'd1, 32'h22);
        checks++; if (commit_valid !== 2'b00) begin errors++; $display("FAIL dual_early: got %b exp 00", commit_valid); end
        wb2(2'b01, 4'd2, 32'h33, 4'd0, 32'h0);
        checks++; if (commit_valid !== 2'b11) begin errors++; $display("FAIL dual_valid: got %b exp 11", commit_valid); end
        checks++; if (commit_we !== 2'b11) begin errors++; $display("FAIL dual_we: got %b exp 11", commit_we); end
        checks++; if (commit_val !== 64'h00000022_00000011) begin errors++; $display("FAIL dual_val: got %h exp 0000002200000011", commit_val); end
        checks++; if (commit_id !== 8'h10) begin errors++; $display("FAIL dual_id: got %h exp 10", commit_id); end
        checks++; if (commit_rd !== 10'h041) begin errors++; $display("FAIL dual_rd: got %h exp 041", commit_rd); end
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL dual_count1: got %0d exp 1", count); end
        step();
        checks++; if (commit_valid !== 2'b01) begin errors++; $display("FAIL single_valid: got %b exp 01", commit_valid); end
        checks++; if (commit_id[3:0] !== 4'd2 || commit_val[31:0] !== 32'h33) begin
            errors++; $display("FAIL single_id_val: got %0d/%h exp 2/33", commit_id[3:0], commit_val[31:0]); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL single_count: got %0d exp 0", count); end
        step();
        checks++; if (commit_valid !== 2'b00) begin errors++; $display("FAIL dual_quiet: got %b exp 00", commit_valid); end
        checks++; if (head_id !== 4'd3) begin errors++; $display("FAIL dual_head: got %0d exp 3", head_id); end
    endtask

    task automatic test_full();
        do_reset();
        issue_valid = 1'b1; issue_type = RG; issue_rd = 5'd4;
        for (int i = 0; i < 15; i++) step();
        checks++; if (count !== 5'd15 || issue_ready !== 1'b1) begin
            errors++; $display("FAIL full_15: got count %0d ready %b exp 15/1", count, issue_ready); end
        step();
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL full_count: got %0d exp 16", count); end
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b exp 0", issue_ready); end
        checks++; if (issue_id !== 4'd0) begin errors++; $display("FAIL full_wrap: got %0d exp 0", issue_id); end
        wb2(2'b01, 4'd0, 32'h44, 4'd0, 32'h0);
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL full_hold: got %0d exp 16", count); end
        step();
        checks++; if (commit_valid !== 2'b01 || count !== 5'd15) begin
            errors++; $display("FAIL full_commit: got valid %b count %0d exp 01/15", commit_valid, count); end
        checks++; if (issue_ready !== 1'b1 || issue_id !== 4'd0) begin
            errors++; $display("FAIL full_freed: got ready %b id %0d exp 1/0", issue_ready, issue_id); end
        step();
        issue_valid = 1'b0;
        checks++; if (count !== 5'd16 || issue_id !== 4'd1 || head_id !== 4'd1) begin
            errors++; $display("FAIL full_reuse: got count %0d tail %0d head %0d exp 16/1/1", count, issue_id, head_id); end
    endtask

    task automatic test_flush();
        do_reset();
        issue_one(BR, 5'd0, 32'h100);
        issue_one(RG, 5'd5, 32'h0);
        issue_one(RG, 5'd6, 32'h0);
        wb2(2'b11, 4'd0, 32'h200, 4'd1, 32'h55);
        step();
        checks++; if (flush !== 1'b1 || redirect_valid !== 1'b1) begin
            errors++; $display("FAIL flush_pulse: got flush %b redir %b exp 1/1", flush, redirect_valid); end
        checks++; if (redirect_pc !== 32'h200) begin errors++; $display("FAIL flush_pc: got %h exp 200", redirect_pc); end
        checks++; if (commit_valid !== 2'b01 || commit_we !== 2'b00) begin
            errors++; $display("FAIL flush_commit: got valid %b we %b exp 01/00", commit_valid, commit_we); end
        issue_valid = 1'b1; issue_type = RG;
        wb_valid = 2'b01; wb_id = {4'd0, 4'd2}; wb_val = {32'h0, 32'h66};
        step();
        idle();
        checks++; if (flush !== 1'b0 || redirect_valid !== 1'b0) begin
            errors++; $display("FAIL flush_one_cycle: got flush %b redir %b exp 0/0", flush, redirect_valid); end
        checks++; if (count !== 5'd0 || head_id !== 4'd0 || issue_id !== 4'd0) begin
            errors++; $display("FAIL flush_clear: got count %0d head %0d tail %0d exp 0/0/0", count, head_id, issue_id); end
        checks++; if (commit_valid !== 2'b00) begin errors++; $display("FAIL flush_no_commit: got %b exp 00", commit_valid); end
        wb2(2'b01, 4'd1, 32'h77, 4'd0, 32'h0);
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL flush_stale_wb_count: got %0d exp 0", count); end
        lk_dep_a = 1'b1; lk_id_a = 4'd1;
        step();
        lk_dep_a = 1'b0;
        checks++; if (lk_pend_a !== 1'b1 || lk_tag_a !== 4'd1) begin
            errors++; $display("FAIL flush_stale_wb_ignored: got pend %b tag %0d exp 1/1", lk_pend_a, lk_tag_a); end
    endtask

    task automatic test_jalr();
        do_reset();
        issue_one(JALR, 5'd1, 32'h1004);
        issue_one(RG, 5'd2, 32'h0);
        wb2(2'b11, 4'd0, 32'h3000, 4'd1, 32'h99);
        step();
        checks++; if (commit_valid !== 2'b01 || commit_we !== 2'b01) begin
            errors++; $display("FAIL jalr_slot0: got valid %b we %b exp 01/01", commit_valid, commit_we); end
        checks++; if (commit_val[31:0] !== 32'h1004 || commit_rd[4:0] !== 5'd1) begin
            errors++; $display("FAIL jalr_link: got val %h rd %0d exp 1004/1", commit_val[31:0], commit_rd[4:0]); end
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h3000 || flush !== 1'b0) begin
            errors++; $display("FAIL jalr_redirect: got v %b pc %h flush %b exp 1/3000/0", redirect_valid, redirect_pc, flush); end
        step();
        checks++; if (commit_valid !== 2'b01 || commit_id[3:0] !== 4'd1 || commit_val[31:0] !== 32'h99) begin
            errors++; $display("FAIL jalr_next_rg: got valid %b id %0d val %h exp 01/1/99", commit_valid, commit_id[3:0], commit_val[31:0]); end
        checks++; if (redirect_valid !== 1'b0 || count !== 5'd0) begin
            errors++; $display("FAIL jalr_after: got redir %b count %0d exp 0/0", redirect_valid, count); end
    endtask

    task automatic test_stores();
        do_reset();
        issue_one(ST, 5'd0, 32'h0);
        issue_one(ST, 5'd0, 32'h0);
        wb2(2'b11, 4'd0, 32'h0, 4'd1, 32'h0);
        step();
        checks++; if (st_commit !== 1'b1 || st_commit_id !== 4'd0 || commit_valid !== 2'b01 || commit_we !== 2'b00) begin
            errors++; $display("FAIL st_first: got st %b id %0d valid %b we %b exp 1/0/01/00", st_commit, st_commit_id, commit_valid, commit_we); end
        step();
        checks++; if (st_commit !== 1'b1 || st_commit_id !== 4'd1 || commit_valid !== 2'b01) begin
            errors++; $display("FAIL st_second: got st %b id %0d valid %b exp 1/1/01", st_commit, st_commit_id, commit_valid); end
        step();
        checks++; if (st_commit !== 1'b0) begin errors++; $display("FAIL st_done: got %b exp 0", st_commit); end
    endtask

    task automatic test_lookup();
        do_reset();
        issue_valid = 1'b1; issue_type = RG; issue_rd = 5'd9;
        for (int i = 0; i < 6; i++) step();
        issue_valid = 1'b0;
        lk_dep_a = 1'b1; lk_id_a = 4'd5; lk_dep_b = 1'b0; lk_rf_b = 32'h1234;
        step();
        checks++; if (lk_pend_a !== 1'b1 || lk_tag_a !== 4'd5 || lk_data_a !== 32'h0) begin
            errors++; $display("FAIL lk_pending: got pend %b tag %0d data %h exp 1/5/0", lk_pend_a, lk_tag_a, lk_data_a); end
        checks++; if (lk_pend_b !== 1'b0 || lk_data_b !== 32'h1234 || lk_tag_b !== 4'd0) begin
            errors++; $display("FAIL lk_rf: got pend %b data %h tag %0d exp 0/1234/0", lk_pend_b, lk_data_b, lk_tag_b); end
        wb2(2'b10, 4'd0, 32'h0, 4'd5, 32'hBEEF);
        checks++; if (lk_pend_a !== 1'b0 || lk_data_a !== 32'hBEEF || lk_tag_a !== 4'd0) begin
            errors++; $display("FAIL lk_forward: got pend %b data %h tag %0d exp 0/beef/0", lk_pend_a, lk_data_a, lk_tag_a); end
        step();
        checks++; if (lk_pend_a !== 1'b0 || lk_data_a !== 32'hBEEF) begin
            errors++; $display("FAIL lk_stored: got pend %b data %h exp 0/beef", lk_pend_a, lk_data_a); end
        idle();
    endtask

    task automatic test_stall();
        do_reset();
        rdy_in = 1'b0;
        issue_one(RG, 5'd7, 32'h0);
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL stall_issue: got %0d exp 0", count); end
        rdy_in = 1'b1;
        issue_one(RG, 5'd7, 32'h0);
        wb2(2'b01, 4'd0, 32'h5, 4'd0, 32'h0);
        rdy_in = 1'b0;
        step();
        checks++; if (commit_valid !== 2'b00 || count !== 5'd1) begin
            errors++; $display("FAIL stall_commit: got valid %b count %0d exp 00/1", commit_valid, count); end
        rdy_in = 1'b1;
        step();
        checks++; if (commit_valid !== 2'b01 || commit_val[31:0] !== 32'h5 || count !== 5'd0) begin
            errors++; $display("FAIL stall_release: got valid %b val %h count %0d exp 01/5/0", commit_valid, commit_val[31:0], count); end
    endtask

    initial begin
        idle();
        rst_n_in = 1'b0;
        test_reset();
        test_dual_commit();
        test_full();
        test_flush();
        test_jalr();
        test_stores();
        test_lookup();
        test_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
